writeback_regfile: RTL and testbench

WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

---
 rtl/writeback_regfile.sv | 132 +++++++++++++
 tb/tb_writeback_regfile.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/writeback_regfile.sv
// -----------------------------------------------------------------------------
// writeback_regfile
//   32 x DATA_WIDTH integer register file with writeback bypass and a per-
//   register busy scoreboard used by decode to detect read-after-write hazards.
//
// Ports
//   clock        in   single clock, all state updates on the rising edge
//   reset        in   asynchronous active-low reset
//   write        in   writeback write enable
//   write_reg    in   [4:0] writeback destination index
//   write_data   in   [DATA_WIDTH-1:0] writeback data
//   read_sel1/2  in   [4:0] read port indices
//   issue_valid  in   decode issued an instruction that will write issue_reg
//   issue_reg    in   [4:0] destination of the issued instruction
//   report       in   print enable, no functional effect
//   read_data1/2 out  [DATA_WIDTH-1:0] read data (bypassed from writeback)
//   hazard       out  a non-bypassed source register is still pending
//   busy_count   out  [5:0] registered number of pending registers
//   orphan_write out  sticky: writeback hit a register that was not pending
// -----------------------------------------------------------------------------
module writeback_regfile #(
    parameter int CORE       = 0,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  write,
    input  logic [4:0]            write_reg,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [4:0]            read_sel1,
    input  logic [4:0]            read_sel2,
    input  logic                  issue_valid,
    input  logic [4:0]            issue_reg,
    input  logic                  report,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2,
    output logic                  hazard,
    output logic [5:0]            busy_count,
    output logic                  orphan_write
);

    logic [DATA_WIDTH-1:0] regs_q [32];
    logic [31:0]           busy_q, busy_d;
    logic [5:0]            busy_count_q, busy_count_d;
    logic                  orphan_q, orphan_d;

    logic commit;
    logic issue;

    // x0 is hard-wired, so neither a write nor an issue to it means anything.
    assign commit = write && (write_reg != 5'd0);
    assign issue  = issue_valid && (issue_reg != 5'd0);

    // report and CORE only select simulation printing; they do not steer logic.
    logic unused_report;
    assign unused_report = report ^ (CORE != 0);

    // ---------------------------------------------------------------- storage
    // NOTE: the register array is reset as well, because reads after reset
    // must return 0 and synthesis cannot rely on power-up contents.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (commit) begin
            regs_q[write_reg] <= write_data;
        end
    end

    // ------------------------------------------------------------- scoreboard
    // Clear is applied before set so an issue and a writeback to the same
    // register in one cycle leaves it busy: the newer producer still pending.
    always_comb begin
        busy_d = busy_q;
        if (commit) busy_d[write_reg] = 1'b0;
        if (issue)  busy_d[issue_reg] = 1'b1;
        busy_d[0] = 1'b0;

        busy_count_d = '0;
        for (int i = 1; i < 32; i++) begin
            busy_count_d = busy_count_d + 6'(busy_d[i]);
        end

        orphan_d = orphan_q | (commit & ~busy_q[write_reg]);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy_q       <= '0;
            busy_count_q <= '0;
            orphan_q     <= 1'b0;
        end else begin
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
            orphan_q     <= orphan_d;
        end
    end

    // ----------------------------------------------------------- read ports
    // Outputs are forced low during reset so the bypass path cannot leak
    // write_data while the array is being cleared.
    function automatic logic [DATA_WIDTH-1:0] read_port(input logic [4:0] sel);
        logic [DATA_WIDTH-1:0] data;
        data = '0;
        if (reset && (sel != 5'd0)) begin
            if (commit && (write_reg == sel)) data = write_data;
            else                              data = regs_q[sel];
        end
        return data;
    endfunction

    // A source is a hazard only if it is pending and not satisfied by the
    // writeback happening this very cycle.
    function automatic logic src_hazard(input logic [4:0] sel);
        return reset && (sel != 5'd0) && busy_q[sel] && !(write && (write_reg == sel));
    endfunction

    // NOTE: every combinational output gets a value on every path; the helper
    // functions initialise their result first so no latch is inferred.
    always_comb begin
        read_data1 = read_port(read_sel1);
        read_data2 = read_port(read_sel2);
        hazard     = src_hazard(read_sel1) || src_hazard(read_sel2);
    end

    assign busy_count   = busy_count_q;
    assign orphan_write = orphan_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// -----------------------------------------------------------------------------
// tb_writeback_regfile
//   Directed, table-driven bench for writeback_regfile. Each table row drives
//   one cycle of inputs, checks the combinational outputs before the edge and
//   the registered outputs after it. Hand-written sequences cover mid-cycle
//   reset and recovery.
// -----------------------------------------------------------------------------
module tb_writeback_regfile;

    localparam int DW = 32;

    logic          clock;
    logic          reset;
    logic          write;
    logic [4:0]    write_reg;
    logic [DW-1:0] write_data;
    logic [4:0]    read_sel1;
    logic [4:0]    read_sel2;
    logic          issue_valid;
    logic [4:0]    issue_reg;
    logic          report;
    logic [DW-1:0] read_data1;
    logic [DW-1:0] read_data2;
    logic          hazard;
    logic [5:0]    busy_count;
    logic          orphan_write;

    int errors = 0;
    int checks = 0;

    writeback_regfile #(.CORE(0), .DATA_WIDTH(DW)) dut (
        .clock        (clock),
        .reset        (reset),
        .write        (write),
        .write_reg    (write_reg),
        .write_data   (write_data),
        .read_sel1    (read_sel1),
        .read_sel2    (read_sel2),
        .issue_valid  (issue_valid),
        .issue_reg    (issue_reg),
        .report       (report),
        .read_data1   (read_data1),
        .read_data2   (read_data2),
        .hazard       (hazard),
        .busy_count   (busy_count),
        .orphan_write (orphan_write)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    typedef struct {
        logic          wr;
        logic [4:0]    wreg;
        logic [DW-1:0] wdata;
        logic [4:0]    sel1;
        logic [4:0]    sel2;
        logic          iv;
        logic [4:0]    ireg;
        logic [DW-1:0] exp_rd1;     // before the edge
        logic [DW-1:0] exp_rd2;     // before the edge
        logic          exp_hazard;  // before the edge
        logic [5:0]    exp_count;   // after the edge
        logic          exp_orphan;  // after the edge
    } vec_t;

    vec_t vecs[14];

    task automatic drive_idle();
        write       = 1'b0;
        write_reg   = '0;
        write_data  = '0;
        read_sel1   = '0;
        read_sel2   = '0;
        issue_valid = 1'b0;
        issue_reg   = '0;
    endtask

    initial begin
        //            wr wreg wdata     s1 s2 iv ireg rd1       rd2       hz cnt orph
        vecs[0]  = '{0, 0,  32'h0,    3, 0, 1, 3,  32'h0,    32'h0,    0, 1, 0}; // issue x3
        vecs[1]  = '{1, 3,  32'h5,    0, 3, 0, 0,  32'h0,    32'h5,    0, 0, 0}; // write x3, bypass port 2
        vecs[2]  = '{0, 0,  32'h0,    3, 0, 0, 0,  32'h5,    32'h0,    0, 0, 0}; // read back x3
        vecs[3]  = '{1, 0,  32'h9,    0, 0, 0, 0,  32'h0,    32'h0,    0, 0, 0}; // write x0 ignored
        vecs[4]  = '{0, 0,  32'h0,    3, 0, 1, 7,  32'h5,    32'h0,    0, 1, 0}; // issue x7
        vecs[5]  = '{0, 0,  32'h0,    7, 0, 0, 0,  32'h0,    32'h0,    1, 1, 0}; // x7 pending
        vecs[6]  = '{1, 7,  32'h77,   7, 0, 0, 0,  32'h77,   32'h0,    0, 0, 0}; // writeback clears hazard
        vecs[7]  = '{0, 0,  32'h0,    0, 0, 1, 4,  32'h0,    32'h0,    0, 1, 0}; // issue x4
        vecs[8]  = '{1, 4,  32'h44,   0, 4, 1, 4,  32'h0,    32'h44,   0, 1, 0}; // set+clear x4: stays busy
        vecs[9]  = '{0, 0,  32'h0,    4, 0, 1, 4,  32'h44,   32'h0,    1, 1, 0}; // WAW issue x4
        vecs[10] = '{1, 4,  32'h45,   4, 0, 0, 0,  32'h45,   32'h0,    0, 0, 0}; // first writeback clears
        vecs[11] = '{1, 10, 32'hA,    0, 0, 0, 0,  32'h0,    32'h0,    0, 0, 1}; // orphan write x10
        vecs[12] = '{0, 0,  32'h0,    10, 7, 0, 0, 32'hA,    32'h77,   0, 0, 1}; // orphan sticky
        vecs[13] = '{0, 0,  32'h0,    0, 0, 0, 0,  32'h0,    32'h0,    0, 0, 1}; // orphan sticky

        report = 1'b0;
        drive_idle();
        reset = 1'b0;
        #1;
        check("reset_rd1",    read_data1,   32'h0);
        check("reset_hazard", hazard,       32'h0);
        check("reset_count",  busy_count,   32'h0);
        check("reset_orphan", orphan_write, 32'h0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 14; i++) begin
            @(negedge clock);
            write       = vecs[i].wr;
            write_reg   = vecs[i].wreg;
            write_data  = vecs[i].wdata;
            read_sel1   = vecs[i].sel1;
            read_sel2   = vecs[i].sel2;
            issue_valid = vecs[i].iv;
            issue_reg   = vecs[i].ireg;
            #1;
            check($sformatf("v%0d_rd1", i),    read_data1, vecs[i].exp_rd1);
            check($sformatf("v%0d_rd2", i),    read_data2, vecs[i].exp_rd2);
            check($sformatf("v%0d_hazard", i), hazard,     32'(vecs[i].exp_hazard));
            @(posedge clock);
            #1;
            check($sformatf("v%0d_count", i),  busy_count,   32'(vecs[i].exp_count));
            check($sformatf("v%0d_orphan", i), orphan_write, 32'(vecs[i].exp_orphan));
        end

        // Fill the scoreboard with x1..x5.
        for (int r = 1; r <= 5; r++) begin
            @(negedge clock);
            drive_idle();
            issue_valid = 1'b1;
            issue_reg   = 5'(r);
            @(posedge clock);
        end
        @(negedge clock);
        drive_idle();
        read_sel1 = 5'd1;
        read_sel2 = 5'd3;
        #1;
        check("fill_count",  busy_count, 32'd5);
        check("fill_hazard", hazard,     32'h1);

        // Reset between edges with a write (and its bypass) in flight.
        #2;
        reset      = 1'b0;
        write      = 1'b1;
        write_reg  = 5'd6;
        write_data = 32'h66;
        read_sel2  = 5'd6;
        #1;
        check("mid_reset_count",  busy_count,   32'h0);
        check("mid_reset_hazard", hazard,       32'h0);
        check("mid_reset_rd1",    read_data1,   32'h0);
        check("mid_reset_rd2",    read_data2,   32'h0);
        check("mid_reset_orphan", orphan_write, 32'h0);
        @(posedge clock);

        @(negedge clock);
        reset = 1'b1;
        drive_idle();
        read_sel1 = 5'd6;
        read_sel2 = 5'd3;
        #1;
        check("post_reset_x6", read_data1, 32'h0);
        check("post_reset_x3", read_data2, 32'h0);
        check("post_reset_hazard", hazard, 32'h0);

        // Operation resumes: a write to the non-pending x6 commits and is orphaned.
        @(negedge clock);
        write      = 1'b1;
        write_reg  = 5'd6;
        write_data = 32'h66;
        @(posedge clock);
        #1;
        check("resume_orphan", orphan_write, 32'h1);
        @(negedge clock);
        drive_idle();
        read_sel1 = 5'd6;
        #1;
        check("resume_x6", read_data1, 32'h66);
        check("resume_count", busy_count, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
